// File: rtl/hdmi_clk_pkg.sv
// Shared types and helpers for the HDMI serial-domain reset sequencer.
package hdmi_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK   = 2'd0,
    STABLE      = 2'd1,
    SER_RELEASE = 2'd2,
    RUN         = 2'd3
  } seq_state_e;

  localparam int unsigned RELOCK_W = 8;

  // Saturating increment used by the lock-loss counter.
  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    if (v == {RELOCK_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(RELOCK_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability settling chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hdmi_clk_rst_seq.sv
// Serial-domain reset sequencer: qualifies PLL lock, then releases the
// serialiser reset followed by the pixel reset; drops both on lock loss.
module hdmi_clk_rst_seq
  import hdmi_clk_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned SER_TO_PIX_CYCLES  = 16,
  parameter int unsigned CNT_W              = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pll_lock,
  input  logic                clear_count,
  output logic                ser_rstn,
  output logic                pix_rstn,
  output logic                ready,
  output logic [1:0]          state,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SER_LAST    = CNT_W'(SER_TO_PIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic                lock_s;
  logic                lost_in_run_s;
  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ser_q, ser_d;
  logic                pix_q, pix_d;
  logic                rdy_q, rdy_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i  (clk),
    .rst_ni (resetn),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  // Next-state and next-output logic; outputs are computed one edge ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ser_d         = ser_q;
    pix_d         = pix_q;
    rdy_d         = rdy_q;
    lost_in_run_s = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = {CNT_W{1'b0}};
        ser_d = 1'b0;
        pix_d = 1'b0;
        rdy_d = 1'b0;
        if (lock_s) begin
          state_d = STABLE;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == STABLE_LAST) begin
          state_d = SER_RELEASE;
          cnt_d   = {CNT_W{1'b0}};
          ser_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SER_RELEASE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = {CNT_W{1'b0}};
          ser_d   = 1'b0;
        end else if (cnt_q == SER_LAST) begin
          state_d = RUN;
          cnt_d   = {CNT_W{1'b0}};
          pix_d   = 1'b1;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d       = WAIT_LOCK;
          ser_d         = 1'b0;
          pix_d         = 1'b0;
          rdy_d         = 1'b0;
          lost_in_run_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = {CNT_W{1'b0}};
        ser_d   = 1'b0;
        pix_d   = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  // Lock-loss counter: a clear in the same cycle as a loss takes priority.
  always_comb begin
    if (clear_count) begin
      relock_d = {RELOCK_W{1'b0}};
    end else if (lost_in_run_s) begin
      relock_d = sat_inc(relock_q);
    end else begin
      relock_d = relock_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= {CNT_W{1'b0}};
      ser_q    <= 1'b0;
      pix_q    <= 1'b0;
      rdy_q    <= 1'b0;
      relock_q <= {RELOCK_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ser_q    <= ser_d;
      pix_q    <= pix_d;
      rdy_q    <= rdy_d;
      relock_q <= relock_d;
    end
  end

  assign ser_rstn     = ser_q;
  assign pix_rstn     = pix_q;
  assign ready        = rdy_q;
  assign state        = state_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_hdmi_clk_rst_seq.sv
// Self-checking bench for hdmi_clk_rst_seq using a run-length reference model.
module tb_hdmi_clk_rst_seq;

  localparam int N = 8;
  localparam int M = 4;
  localparam int RCAP = 1 << 20;

  logic       clk;
  logic       resetn;
  logic       pll_lock;
  logic       clear_count;
  logic       ser_rstn;
  logic       pix_rstn;
  logic       ready;
  logic [1:0] state;
  logic [7:0] relock_count;

  int errors = 0;
  int checks = 0;

  // Model: r_hist[k] = length of the run of consecutive pll_lock=1 samples
  // ending at the edge k edges ago. The FSM acts on the sample two edges old.
  int         r_hist[4];
  logic [7:0] m_relock;

  hdmi_clk_rst_seq #(
    .LOCK_STABLE_CYCLES (N),
    .SER_TO_PIX_CYCLES  (M),
    .CNT_W              (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_lock     (pll_lock),
    .clear_count  (clear_count),
    .ser_rstn     (ser_rstn),
    .pix_rstn     (pix_rstn),
    .ready        (ready),
    .state        (state),
    .relock_count (relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] act_v;
  assign act_v = {ser_rstn, pix_rstn, ready, state, relock_count};

  assert property (@(posedge clk) pix_rstn |-> ser_rstn)
  else begin
    errors++;
    $display("FAIL invariant pix_rstn=1 while ser_rstn=0 at %0t", $time);
  end

  function automatic logic [1:0] st_of(input int r);
    if (r == 0)          st_of = 2'd0;
    else if (r <= N)     st_of = 2'd1;
    else if (r <= N + M) st_of = 2'd2;
    else                 st_of = 2'd3;
  endfunction

  function automatic logic [12:0] exp_vec();
    logic s, p;
    s = (r_hist[2] >= N + 1);
    p = (r_hist[2] >= N + M + 1);
    exp_vec = {s, p, p, st_of(r_hist[2]), m_relock};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) r_hist[k] = 0;
    m_relock = 8'd0;
  endtask

  // Advance one edge, update the model with the inputs sampled there, and
  // return 1 time unit after the edge.
  task automatic step();
    int rn;
    @(posedge clk);
    rn = pll_lock ? ((r_hist[0] + 1 > RCAP) ? RCAP : r_hist[0] + 1) : 0;
    r_hist[3] = r_hist[2];
    r_hist[2] = r_hist[1];
    r_hist[1] = r_hist[0];
    r_hist[0] = rn;
    if (clear_count)
      m_relock = 8'd0;
    else if (r_hist[2] == 0 && st_of(r_hist[3]) == 2'd3 && m_relock != 8'd255)
      m_relock = m_relock + 8'd1;
    #1;
  endtask

  task automatic do_reset();
    pll_lock    = 1'b0;
    clear_count = 1'b0;
    resetn      = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    pll_lock    = 1'b0;
    clear_count = 1'b0;
    resetn      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_v !== 13'h0000) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", act_v, 13'h0000);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (act_v !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle got=%h exp=%h", act_v, exp_vec());
      end
    end
  endtask

  task automatic test_stable_lock();
    int first_ser = -1;
    int first_pix = -1;
    pll_lock = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (act_v !== exp_vec()) begin
        errors++;
        $display("FAIL stable_lock edge=%0d got=%h exp=%h", e, act_v, exp_vec());
      end
      if (ser_rstn && first_ser < 0) first_ser = e;
      if (pix_rstn && ready && first_pix < 0) first_pix = e;
    end
    checks++;
    if (first_ser != N + 2) begin
      errors++;
      $display("FAIL ser_release_edge got=%0d exp=%0d", first_ser, N + 2);
    end
    checks++;
    if (first_pix != N + 2 + M) begin
      errors++;
      $display("FAIL pix_release_edge got=%0d exp=%0d", first_pix, N + 2 + M);
    end
  endtask

  task automatic test_loss_in_run();
    int first_low = -1;
    pll_lock = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step();
      checks++;
      if (act_v !== exp_vec()) begin
        errors++;
        $display("FAIL loss_in_run edge=%0d got=%h exp=%h", e, act_v, exp_vec());
      end
      if (!ser_rstn && !pix_rstn && !ready && first_low < 0) first_low = e;
    end
    checks++;
    if (first_low != 2 || relock_count !== 8'd1) begin
      errors++;
      $display("FAIL loss_latency got=%0d/%0d exp=2/1", first_low, relock_count);
    end
    pll_lock = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (act_v !== exp_vec()) begin
        errors++;
        $display("FAIL relock_seq edge=%0d got=%h exp=%h", e, act_v, exp_vec());
      end
    end
  endtask

  task automatic test_glitch_stable();
    int first_ser = -1;
    do_reset();
    pll_lock = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step();
      checks++;
      if (act_v !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_pre edge=%0d got=%h exp=%h", e, act_v, exp_vec());
      end
    end
    pll_lock = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (act_v !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_low got=%h exp=%h", act_v, exp_vec());
      end
    end
    pll_lock = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (act_v !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_relock edge=%0d got=%h exp=%h", e, act_v, exp_vec());
      end
      if (ser_rstn && first_ser < 0) first_ser = e;
    end
    checks++;
    if (first_ser != N + 2 || relock_count !== 8'd0) begin
      errors++;
      $display("FAIL glitch_requal got=%0d/%0d exp=%0d/0", first_ser, relock_count, N + 2);
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    for (int k = 0; k < 260; k++) begin
      pll_lock = 1'b1;
      repeat (N + M + 4) begin
        step();
        checks++;
        if (act_v !== exp_vec()) begin
          errors++;
          $display("FAIL sat_high loop=%0d got=%h exp=%h", k, act_v, exp_vec());
        end
      end
      pll_lock = 1'b0;
      step();
    end
    pll_lock = 1'b1;
    repeat (N + M + 6) step();
    checks++;
    if (relock_count !== 8'd255 || !ready) begin
      errors++;
      $display("FAIL saturation got=%0d ready=%0b exp=255 ready=1", relock_count, ready);
    end
    pll_lock = 1'b0;
    step();
    step();
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    checks++;
    if (act_v !== exp_vec() || relock_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_vs_inc got=%h exp=%h", act_v, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    int first_ser = -1;
    do_reset();
    pll_lock = 1'b1;
    repeat (N + 4) step();
    checks++;
    if (state !== 2'd2 || !ser_rstn) begin
      errors++;
      $display("FAIL pre_async_state got=%0d ser=%0b exp=2 ser=1", state, ser_rstn);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (act_v !== 13'h0000) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", act_v, 13'h0000);
    end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (act_v !== exp_vec()) begin
        errors++;
        $display("FAIL async_restart edge=%0d got=%h exp=%h", e, act_v, exp_vec());
      end
      if (ser_rstn && first_ser < 0) first_ser = e;
    end
    checks++;
    if (first_ser != N + 2) begin
      errors++;
      $display("FAIL async_restart_edge got=%0d exp=%0d", first_ser, N + 2);
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        hold     = pll_lock ? $urandom_range(1, 2 * (N + M)) : $urandom_range(1, 5);
      end
      hold--;
      clear_count = ($urandom_range(0, 40) == 0);
      step();
      checks++;
      if (act_v !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, act_v, exp_vec());
      end
    end
    clear_count = 1'b0;
  endtask

  initial begin
    resetn      = 1'b0;
    pll_lock    = 1'b0;
    clear_count = 1'b0;
    model_reset();
    test_reset();
    test_stable_lock();
    test_loss_in_run();
    test_glitch_stable();
    test_saturation_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
